// File: rtl/demux_1_to_4_df.sv
// Registered 1-to-4 demux: I is steered to slice {S1,S0} of Y, others zeroed.
// Optional per-slice activity counters are compiled in with DEMUX_ACT_CNT_EN.
module demux_1_to_4_df #(
    parameter int DATA_W = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   I,
    input  logic                S1,
    input  logic                S0,
`ifdef DEMUX_ACT_CNT_EN
    input  logic                cnt_clr,
    output logic [31:0]         act_cnt,
`endif
    output logic [4*DATA_W-1:0] Y
);

    logic [1:0]          w_sel;
    logic [4*DATA_W-1:0] w_y_nxt;
    logic [4*DATA_W-1:0] r_y;

    assign w_sel = {S1, S0};

    always_comb begin
        w_y_nxt = '0;
        unique case (w_sel)
            2'b00: w_y_nxt[0*DATA_W +: DATA_W] = I;
            2'b01: w_y_nxt[1*DATA_W +: DATA_W] = I;
            2'b10: w_y_nxt[2*DATA_W +: DATA_W] = I;
            2'b11: w_y_nxt[3*DATA_W +: DATA_W] = I;
            default: w_y_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y <= '0;
        end else begin
            r_y <= w_y_nxt;
        end
    end

    assign Y = r_y;

`ifdef DEMUX_ACT_CNT_EN
    logic [3:0]  w_hit;
    logic [7:0]  r_cnt [4];

    // A slice counts as active when the value being written into it is nonzero.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < 4; k++) begin
            w_hit[k] = |w_y_nxt[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n || cnt_clr) begin
                r_cnt[k] <= 8'h00;
            end else if (w_hit[k] && r_cnt[k] != 8'hFF) begin
                r_cnt[k] <= r_cnt[k] + 8'h01;
            end
        end
    end

    assign act_cnt = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

endmodule

// File: tb/tb_demux_1_to_4_df.sv
// Directed self-checking bench for demux_1_to_4_df (DATA_W=1 and DATA_W=4).
// Counter checks are included when DEMUX_ACT_CNT_EN is defined.
module tb_demux_1_to_4_df;

    logic        clk;
    logic        rst_n;
    logic        S1;
    logic        S0;
    logic [0:0]  I1;
    logic [3:0]  I4;
    logic [3:0]  Y1;
    logic [15:0] Y4;
    int          checks;
    int          failures;
`ifdef DEMUX_ACT_CNT_EN
    logic        cnt_clr;
    logic [31:0] cnt1;
    logic [31:0] cnt4;
`endif

    demux_1_to_4_df #(.DATA_W(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .I       (I1),
        .S1      (S1),
        .S0      (S0),
`ifdef DEMUX_ACT_CNT_EN
        .cnt_clr (cnt_clr),
        .act_cnt (cnt1),
`endif
        .Y       (Y1)
    );

    demux_1_to_4_df #(.DATA_W(4)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .I       (I4),
        .S1      (S1),
        .S0      (S0),
`ifdef DEMUX_ACT_CNT_EN
        .cnt_clr (cnt_clr),
        .act_cnt (cnt4),
`endif
        .Y       (Y4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [1:0] s);
        {S1, S0} = s;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        I1       = 1'b1;
        I4       = 4'hA;
        set_sel(2'b10);
`ifdef DEMUX_ACT_CNT_EN
        cnt_clr  = 1'b0;
`endif
        tick();
        tick();
        check("reset_y1", 32'(Y1), 32'h0);
        check("reset_y4", 32'(Y4), 32'h0);
`ifdef DEMUX_ACT_CNT_EN
        check("reset_cnt", cnt1, 32'h0);
`endif

        // Routing sweep, each code held for 20 cycles (200 time units)
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_sel(2'(k));
            tick();
            check($sformatf("sweep1_sel%0d_first", k), 32'(Y1), 32'h1 << k);
            check($sformatf("sweep4_sel%0d_first", k), 32'(Y4), 32'hA << (4 * k));
            for (int n = 1; n < 20; n++) tick();
            check($sformatf("sweep1_sel%0d_hold", k), 32'(Y1), 32'h1 << k);
        end

        // No combinational path: new select not visible before the edge
        set_sel(2'b00);
        #1;
        check("no_comb_path", 32'(Y1), 32'h8);
        tick();
        check("latency_one_edge", 32'(Y1), 32'h1);

        // Zero data
        I1 = 1'b0;
        I4 = 4'h0;
        for (int k = 0; k < 4; k++) begin
            set_sel(2'(k));
            tick();
            check($sformatf("zero1_sel%0d", k), 32'(Y1), 32'h0);
            check($sformatf("zero4_sel%0d", k), 32'(Y4), 32'h0);
        end

        // Mid-stream reset
        I1 = 1'b1;
        set_sel(2'b11);
        tick();
        check("mid_pre", 32'(Y1), 32'h8);
        rst_n = 1'b0;
        tick();
        check("mid_reset", 32'(Y1), 32'h0);
        rst_n = 1'b1;
        set_sel(2'b01);
        tick();
        check("mid_release", 32'(Y1), 32'h2);

        // Wide data
        I4 = 4'hA;
        set_sel(2'b10);
        tick();
        check("wide_sel10", 32'(Y4), 32'h0A00);
        set_sel(2'b00);
        tick();
        check("wide_sel00", 32'(Y4), 32'h000A);

`ifdef DEMUX_ACT_CNT_EN
        cnt_clr = 1'b1;
        set_sel(2'b01);
        tick();
        check("cnt_clr_prio", cnt1, 32'h0);
        check("cnt_clr_y", 32'(Y1), 32'h2);
        cnt_clr = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        check("cnt_5", cnt1, 32'h0000_0500);
        for (int n = 5; n < 300; n++) tick();
        check("cnt_sat", cnt1, 32'h0000_FF00);
        I1 = 1'b0;
        tick();
        check("cnt_zero_data_hold", cnt1, 32'h0000_FF00);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt_clear", cnt1, 32'h0);
        I1 = 1'b1;
        set_sel(2'b11);
        tick();
        check("cnt_restart", cnt1, 32'h0100_0000);
        cnt_clr = 1'b1;
        rst_n   = 1'b0;
        tick();
        check("cnt_reset", cnt1, 32'h0);
        cnt_clr = 1'b0;
        rst_n   = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
